fetch_queue: RTL

- Instruction buffer between the fetch stage (PC register plus instruction memory) and the decode stage.
- Accepts {PC, instruction} pairs with a valid/ready handshake and presents them in order to decode.
- Provides back-pressure; fetch_stall drives the fetch stage's PC enable low.
- Discards all buffered entries on a control-flow redirect (jump/branch taken).

---
 rtl/fetch_queue_pkg.sv | 19 +
 rtl/fq_ptr.sv | 23 ++
 rtl/fetch_queue.sv | 80 ++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared CPU front-end definitions: reset PC, instruction width and the
// entry format carried from fetch to decode.
package cpu_defs;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int          INSTR_W  = 32;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
        logic               adel;
    } fetch_entry_t;

    // Word-aligned instruction fetch requires the two low PC bits clear.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fq_ptr.sv
// Wrapping queue pointer with a synchronous load (priority) and increment.
module fq_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: in-order circular queue with
// back-pressure, redirect flush and a registered (non fall-through) head.
module fetch_queue
    import cpu_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic               fetch_stall,
    input  logic               flush,
    output logic               out_valid,
    output logic [31:0]        out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_adel,
    input  logic               out_ready,
    output logic [PTR_W:0]     count
);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    fetch_entry_t   mem [DEPTH];
    fetch_entry_t   head;

    // The extra MSB distinguishes full from empty when slot indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                   (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign count = wr_ptr - rd_ptr;

    // in_ready comes from registered state only, so a full queue refuses a
    // push even when decode pops in the same cycle.
    assign in_ready    = ~full;
    assign fetch_stall = full;
    assign out_valid   = ~empty;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    fq_ptr #(.W(PTR_W + 1)) u_wr_ptr (
        .clk      (clk),
        .reset    (reset),
        .inc      (push),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (wr_ptr)
    );

    // Flush collapses the queue by snapping the read pointer onto the write pointer.
    fq_ptr #(.W(PTR_W + 1)) u_rd_ptr (
        .clk      (clk),
        .reset    (reset),
        .inc      (pop),
        .load     (flush),
        .load_val (wr_ptr),
        .ptr      (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= '{pc: in_pc, instr: in_instr, adel: pc_misaligned(in_pc)};
        end
    end

    // Storage is never reset, so the head is masked to keep X off decode.
    assign head      = mem[rd_ptr[PTR_W-1:0]];
    assign out_pc    = empty ? 32'h0 : head.pc;
    assign out_instr = empty ? '0 : head.instr;
    assign out_adel  = empty ? 1'b0 : head.adel;

endmodule
